// File: rtl/baud_tick_gen_frac_if.sv
// Control/status bundle for the fractional baud tick generator.
// The host side drives the enable, restart and divisor signals; the generator drives the ticks.
interface baud_tick_gen_frac_if #(
  parameter int unsigned INT_W  = 8,
  parameter int unsigned FRAC_W = 4
);
  logic              en;
  logic              restart;
  logic [INT_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              tick;
  logic              mid_tick;
  logic              bit_tick;
  logic              pending;

  modport master (
    output en, restart, div_int, div_frac, div_load,
    input  tick, mid_tick, bit_tick, pending
  );

  modport slave (
    input  en, restart, div_int, div_frac, div_load,
    output tick, mid_tick, bit_tick, pending
  );
endinterface

// File: rtl/baud_tick_gen_frac.sv
// Fractional baud tick generator: period = div_int + div_frac/2^FRAC_W clocks, with
// oversample phase, mid-bit/bit-boundary ticks and a shadowed divisor update.
module baud_tick_gen_frac #(
  parameter int unsigned INT_W    = 8,
  parameter int unsigned FRAC_W   = 4,
  parameter int unsigned OVS      = 16,
  parameter int unsigned DEF_INT  = 27,
  parameter int unsigned DEF_FRAC = 0
) (
  input logic                 clk,
  input logic                 reset,
  baud_tick_gen_frac_if.slave bus
);

  localparam int unsigned PH_W = (OVS > 2) ? $clog2(OVS) : 1;

  logic [INT_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic              c;
  logic [PH_W-1:0]   ph;
  logic [INT_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [INT_W-1:0]  sh_int;
  logic [FRAC_W-1:0] sh_frac;
  logic              pend;

  logic [INT_W-1:0]  ie;
  logic [INT_W:0]    last;
  logic              hit;
  logic              tick;
  logic              ph_last;
  logic              apply;

  // Divisor 0 behaves as 1; the carry stretches this period by one clock.
  always_comb begin
    ie      = (act_int == '0) ? INT_W'(1) : act_int;
    last    = ({1'b0, ie} - (INT_W+1)'(1)) + (INT_W+1)'(c);
    hit     = ({1'b0, cnt} == last);
    tick    = bus.en & ~reset & ~bus.restart & hit;
    ph_last = (ph == PH_W'(OVS - 1));
    apply   = tick | ~bus.en | bus.restart;
  end

  assign bus.tick     = tick;
  assign bus.mid_tick = tick & (ph == PH_W'(OVS/2 - 1));
  assign bus.bit_tick = tick & ph_last;
  assign bus.pending  = pend & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      c        <= 1'b0;
      ph       <= '0;
      act_int  <= INT_W'(DEF_INT);
      act_frac <= FRAC_W'(DEF_FRAC);
      sh_int   <= '0;
      sh_frac  <= '0;
      pend     <= 1'b0;
    end else begin
      if (bus.restart) begin
        cnt <= '0;
        acc <= '0;
        c   <= 1'b0;
        ph  <= '0;
      end else if (bus.en) begin
        if (tick) begin
          cnt      <= '0;
          {c, acc} <= {1'b0, acc} + {1'b0, act_frac};
          ph       <= ph_last ? '0 : ph + PH_W'(1);
        end else begin
          cnt <= cnt + INT_W'(1);
        end
      end

      // A load landing in an apply cycle bypasses the shadow so it is never lost.
      if (apply) begin
        if (bus.div_load) begin
          act_int  <= bus.div_int;
          act_frac <= bus.div_frac;
        end else if (pend) begin
          act_int  <= sh_int;
          act_frac <= sh_frac;
        end
        pend <= 1'b0;
      end else if (bus.div_load) begin
        sh_int  <= bus.div_int;
        sh_frac <= bus.div_frac;
        pend    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_baud_tick_gen_frac.sv
// Directed bench for baud_tick_gen_frac with hand-computed tick positions.
module tb_baud_tick_gen_frac;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  baud_tick_gen_frac_if #(.INT_W(8), .FRAC_W(4)) bif ();

  baud_tick_gen_frac #(
    .INT_W(8), .FRAC_W(4), .OVS(16), .DEF_INT(27), .DEF_FRAC(0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  int checks   = 0;
  int failures = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n = cycles from the current cycle to the next tick (-1 if none within budget).
  task automatic wait_tick(input int budget, output int n, output logic m, output logic b);
    n = -1;
    m = 1'b0;
    b = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bif.tick === 1'b1) begin
        n = i;
        m = bif.mid_tick;
        b = bif.bit_tick;
        break;
      end
      @(posedge clk);
      #1;
    end
    step();
  endtask

  task automatic load_restart(input int di, input int df);
    bif.en       = 1'b1;
    bif.div_int  = 8'(di);
    bif.div_frac = 4'(df);
    bif.div_load = 1'b1;
    bif.restart  = 1'b1;
    step();
    bif.div_load = 1'b0;
    bif.restart  = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bif.en       = 1'b1;
    bif.restart  = 1'b0;
    bif.div_load = 1'b0;
    bif.div_int  = '0;
    bif.div_frac = '0;
    repeat (3) step();
    @(negedge clk);
    checks++;
    if ({bif.tick, bif.mid_tick, bif.bit_tick, bif.pending} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0000",
               {bif.tick, bif.mid_tick, bif.bit_tick, bif.pending});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bif.tick, bif.pending} !== 2'b00) begin
      failures++;
      $display("FAIL reset_cycle0 got=%b exp=00", {bif.tick, bif.pending});
    end
    step();
  endtask

  task automatic test_defaults();
    int n, sum, mids, bits;
    logic m, b;
    wait_tick(100, n, m, b);
    checks++;
    if (n !== 25) begin
      failures++;
      $display("FAIL default_first_tick got=%0d exp=25", n);
    end
    for (int k = 2; k <= 16; k++) begin
      wait_tick(100, n, m, b);
      checks++;
      if (n !== 26 || m !== (k == 8) || b !== (k == 16)) begin
        failures++;
        $display("FAIL default_tick%0d got n=%0d m=%b b=%b exp n=26 m=%b b=%b",
                 k, n, m, b, (k == 8), (k == 16));
      end
    end
    sum = 0; mids = 0; bits = 0;
    for (int k = 17; k <= 32; k++) begin
      wait_tick(100, n, m, b);
      sum  += n + 1;
      mids += int'(m);
      bits += int'(b);
    end
    checks++;
    if (sum !== 432 || mids !== 1 || bits !== 1 || b !== 1'b1) begin
      failures++;
      $display("FAIL default_bit_span got sum=%0d mids=%0d bits=%0d last_b=%b exp 432 1 1 1",
               sum, mids, bits, b);
    end
  endtask

  task automatic test_frac();
    int n, total;
    logic m, b;
    int per[5] = '{27, 27, 28, 27, 28};
    load_restart(27, 8);
    checks++;
    if (bif.pending !== 1'b0) begin
      failures++;
      $display("FAIL frac_direct_load pending got=%b exp=0", bif.pending);
    end
    total = 0;
    for (int k = 0; k < 32; k++) begin
      wait_tick(100, n, m, b);
      total += n + 1;
      if (k < 5) begin
        checks++;
        if (n + 1 !== per[k]) begin
          failures++;
          $display("FAIL frac_period%0d got=%0d exp=%0d", k, n + 1, per[k]);
        end
      end
    end
    checks++;
    if (total !== 879) begin
      failures++;
      $display("FAIL frac_span32 got=%0d exp=879", total);
    end
  endtask

  task automatic test_load();
    int n;
    logic m, b;
    load_restart(27, 0);
    repeat (5) step();
    bif.div_int  = 8'd10;
    bif.div_frac = 4'd0;
    bif.div_load = 1'b1;
    step();
    bif.div_load = 1'b0;
    checks++;
    if (bif.pending !== 1'b1) begin
      failures++;
      $display("FAIL load_pending_set got=%b exp=1", bif.pending);
    end
    wait_tick(100, n, m, b);
    checks++;
    if (n !== 20 || bif.pending !== 1'b0) begin
      failures++;
      $display("FAIL load_old_period got n=%0d pending=%b exp n=20 pending=0", n, bif.pending);
    end
    for (int k = 0; k < 2; k++) begin
      wait_tick(100, n, m, b);
      checks++;
      if (n !== 9) begin
        failures++;
        $display("FAIL load_new_period%0d got=%0d exp=9", k, n);
      end
    end
  endtask

  task automatic test_stall();
    int n, seen;
    logic m, b;
    load_restart(27, 0);
    repeat (12) step();
    bif.en = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bif.tick !== 1'b0) seen++;
      step();
    end
    bif.en = 1'b1;
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL stall_no_ticks got=%0d exp=0", seen);
    end
    wait_tick(100, n, m, b);
    checks++;
    if (n !== 14) begin
      failures++;
      $display("FAIL stall_resume got=%0d exp=14", n);
    end
  endtask

  task automatic test_restart();
    int n;
    logic m, b;
    load_restart(27, 0);
    for (int k = 0; k < 7; k++) wait_tick(100, n, m, b);
    repeat (20) step();
    bif.restart = 1'b1;
    @(negedge clk);
    checks++;
    if (bif.tick !== 1'b0) begin
      failures++;
      $display("FAIL restart_no_tick got=%b exp=0", bif.tick);
    end
    step();
    bif.restart = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      wait_tick(100, n, m, b);
      if (k == 1) begin
        checks++;
        if (n !== 26) begin
          failures++;
          $display("FAIL restart_first_tick got=%0d exp=26", n);
        end
      end
      checks++;
      if (m !== (k == 8)) begin
        failures++;
        $display("FAIL restart_mid%0d got=%b exp=%b", k, m, (k == 8));
      end
    end
  endtask

  task automatic test_min_div();
    int n, seen;
    logic m, b;
    int exp_n[5] = '{0, 0, 1, 0, 1};
    load_restart(0, 0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bif.tick === 1'b1) seen++;
      step();
    end
    checks++;
    if (seen !== 5) begin
      failures++;
      $display("FAIL div0_every_clk got=%0d exp=5", seen);
    end
    load_restart(1, 8);
    for (int k = 0; k < 5; k++) begin
      wait_tick(10, n, m, b);
      checks++;
      if (n !== exp_n[k]) begin
        failures++;
        $display("FAIL div1_frac_period%0d got=%0d exp=%0d", k, n + 1, exp_n[k] + 1);
      end
    end
    // Reset while ticking every clock must mask outputs immediately.
    load_restart(0, 0);
    step();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bif.tick, bif.mid_tick, bif.bit_tick} !== 3'b000) begin
      failures++;
      $display("FAIL midrun_reset_outputs got=%b exp=000", {bif.tick, bif.mid_tick, bif.bit_tick});
    end
    step();
    reset = 1'b0;
    repeat (3) step();
    bif.div_int  = 8'd5;
    bif.div_frac = 4'd0;
    bif.div_load = 1'b1;
    step();
    bif.div_load = 1'b0;
    checks++;
    if (bif.pending !== 1'b1) begin
      failures++;
      $display("FAIL shadow_pending got=%b exp=1", bif.pending);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bif.pending !== 1'b0) begin
      failures++;
      $display("FAIL reset_pending got=%b exp=0", bif.pending);
    end
    step();
    reset = 1'b0;
    wait_tick(100, n, m, b);
    checks++;
    if (n !== 26) begin
      failures++;
      $display("FAIL shadow_discarded got=%0d exp=26", n);
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_frac();
    test_load();
    test_stall();
    test_restart();
    test_min_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
